keccak_absorb_frontend: RTL and testbench
=========================================

Name: keccak_absorb_frontend

Overview:
- Parametrised successor to the Keccak load stage plus its set/reset handshake latches.
- Accepts a framed message stream on a W-bit valid/ready bus (active-high).
- Packs the stream into rate-sized blocks, applies the Keccak pad10*1 padding with the domain byte, and queues blocks in a DEPTH-entry block FIFO.
- Feeds the permutation stage through a valid/ready block interface, replacing latch signalling with a true handshake and supporting four hash modes.

Parameters:
W, 64, data bus width in bits; legal values are 32 and 64.
DEPTH, 2, block FIFO entries; legal values are 1 to 4.
RATE_MAX, 1344, widest rate in bits (SHAKE128); sets the block output width.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
in_valid  input  1  input word valid
in_ready  output  1  frontend accepts a word this cycle
in_data  input  W  header or message word; little-endian bytes
blk_valid  output  1  block available at FIFO head
blk_ready  input  1  permute stage consumes the head block
blk_data  output  RATE_MAX  padded block; bits above the mode's rate are 0
blk_last  output  1  head block is the final block of its message
blk_mode  output  2  mode of the head block
blk_out_len  output  32  requested output length in bits; passed through from the header
blk_count  output  32  blocks emitted (optional feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to HDR_MODE; FIFO is emptied; assembly register is zeroed.
  - in_ready=0, blk_valid=0, blk_data=0, blk_last=0, blk_mode=0, blk_out_len=0, blk_count=0.
  - A message in flight is discarded; no partial block is ever emitted.
- Frame format (words in order):
  - Word 0: mode in [1:0]. 00=SHAKE128 (rate 1344), 01=SHAKE256 (1088), 10=SHA3-256 (1088), 11=SHA3-512 (576).
  - Word 1: message length in bytes, L, in [31:0].
  - Word 2: output length in bits in [31:0].
  - Then ceil(L/(W/8)) data words. Bytes beyond L in the final word are masked to 0.
- A word transfers when in_valid && in_ready.
- FSM states:
  - HDR_MODE -> HDR_LEN -> HDR_OLEN: one word each.
  - HDR_OLEN -> DATA when L>0; -> PAD when L==0.
  - DATA:
    - Each word is written at word index k of the assembly register; k wraps at rate/W (21/17/17/9 for W=64; 42/34/34/18 for W=32).
    - On the last data word, if the message ended strictly inside the block, pad bytes are OR-ed in the same cycle. The block is pushed with blk_last=1 and the FSM returns to HDR_MODE.
    - If the message filled the block exactly, the block is pushed with blk_last=0 and the FSM goes to PAD.
    - A full block that is not final is pushed with blk_last=0.
  - PAD: a padding-only block is pushed (domain byte at byte 0, 0x80 at byte rate/8-1), blk_last=1, then the FSM returns to HDR_MODE. No input is accepted in PAD.
- Padding rules:
  - Domain byte is 0x1F for SHAKE and 0x06 for SHA3, placed at byte L mod (rate/8).
  - 0x80 is OR-ed into byte rate/8-1. If both fall on the same byte, the result is 0x9F or 0x86.
- Push and backpressure:
  - A push happens in the cycle after the completing word is accepted, or in the PAD cycle.
  - If the FIFO is full, the push stalls and in_ready=0 until a slot frees.
  - Pop and push in the same cycle on a full FIFO are both allowed.
- Headers are never blocked by the FIFO.
- in_ready is 1 in HDR states; in DATA it is 1 while no push is pending.
- blk_* outputs come from the FIFO head. blk_data, blk_last, blk_mode and blk_out_len are stable while blk_valid && !blk_ready.
- Latency: last word accepted at cycle t gives blk_valid=1 at t+1 when the FIFO was empty.

Optional Feature:
- Macro: KECCAK_FRONTEND_STATS_EN.
- Defined: blk_count increments on each pop and wraps at 2^32.
- Undefined: blk_count is tied to 0 and the counter flops are absent.

Decomposition:
- keccak_pkg holds:
  - rate constants RATE_SHAKE128, RATE_SHAKE256, RATE_SHA3_256, RATE_SHA3_512;
  - the mode enum keccak_mode_t;
  - pad constants PAD_SHAKE=8'h1F, PAD_SHA3=8'h06, PAD_FINAL=8'h80;
  - frontend state enum fe_state_t;
  - a function rate_words(mode, W).
- Sub-module keccak_block_fifo: DEPTH-entry FIFO of {data, last, mode, out_len} with full/empty flags.

Test Plan:
- SHAKE128, W=64, L=0, out_len=256 -> one block: byte0=0x1F, byte167=0x80, all others 0, blk_last=1, blk_out_len=256.
- SHA3-256, L=135, bytes 0x00..0x86 -> single block: byte135=0x86, blk_last=1, bits 1088+ are 0.
- SHA3-256, L=136 -> block 1 is data only with blk_last=0; block 2 has byte0=0x06, byte135=0x80, blk_last=1.
- SHAKE256, W=32, L=5 with final word 0xFFFFFFFF -> bytes 5..7 read 0x1F,0x00,0x00 (masked, then domain byte at 5).
- DEPTH=2, blk_ready=0, SHA3-512 message of 3 full blocks -> in_ready drops after the third block assembles; releasing blk_ready for 1 cycle restores it 1 cycle later; block order is preserved.
- Assert rst=0 mid-DATA for 1 cycle -> blk_valid=0 immediately; a new frame afterwards yields correct blocks; blk_count (with the macro defined) restarts at 0.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared constants, enums and rate helpers for the Keccak absorb frontend.
package keccak_pkg;

  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;
  localparam int RATE_SHA3_256 = 1088;
  localparam int RATE_SHA3_512 = 576;

  localparam logic [7:0] PAD_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_SHA3  = 8'h06;
  localparam logic [7:0] PAD_FINAL = 8'h80;

  typedef enum logic [1:0] {
    MODE_SHAKE128 = 2'b00,
    MODE_SHAKE256 = 2'b01,
    MODE_SHA3_256 = 2'b10,
    MODE_SHA3_512 = 2'b11
  } keccak_mode_t;

  typedef enum logic [2:0] {
    HDR_MODE = 3'd0,
    HDR_LEN  = 3'd1,
    HDR_OLEN = 3'd2,
    DATA     = 3'd3,
    PAD      = 3'd4
  } fe_state_t;

  function automatic logic [7:0] rate_bytes(input keccak_mode_t m);
    case (m)
      MODE_SHAKE128: return 8'(RATE_SHAKE128 / 8);
      MODE_SHAKE256: return 8'(RATE_SHAKE256 / 8);
      MODE_SHA3_256: return 8'(RATE_SHA3_256 / 8);
      MODE_SHA3_512: return 8'(RATE_SHA3_512 / 8);
      default:       return 8'(RATE_SHAKE128 / 8);
    endcase
  endfunction

  function automatic logic [7:0] rate_words(input keccak_mode_t m, input int w);
    return 8'((int'(rate_bytes(m)) * 8) / w);
  endfunction

  // Both SHAKE modes share bit 1 == 0.
  function automatic logic [7:0] domain_byte(input keccak_mode_t m);
    return m[1] ? PAD_SHA3 : PAD_SHAKE;
  endfunction

endpackage

// File: rtl/keccak_absorb_frontend_fifo.sv
// keccak_block_fifo: DEPTH-entry FIFO of packed padded blocks; head is zero when empty.
// Push and pop may coincide on a full FIFO; o_dat is stable until popped.
module keccak_block_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_dat,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dat   = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/keccak_absorb_frontend.sv
// Frames a header+message stream into pad10*1-padded rate blocks and queues them for the permutation.
// Block valid one cycle after its completing word; input stalls while a finished block waits on a full FIFO. Optional KECCAK_FRONTEND_STATS_EN enables blk_count.
module keccak_absorb_frontend
  import keccak_pkg::*;
#(
  parameter int W        = 64,
  parameter int DEPTH    = 2,
  parameter int RATE_MAX = 1344
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic [RATE_MAX-1:0] blk_data,
  output logic                blk_last,
  output logic [1:0]          blk_mode,
  output logic [31:0]         blk_out_len,
  output logic [31:0]         blk_count
);

  localparam int BPW = W / 8;
  localparam int FW  = RATE_MAX + 35;

  fe_state_t           r_state;
  fe_state_t           w_state_nxt;
  keccak_mode_t        r_mode;
  keccak_mode_t        r_pend_mode;
  logic [31:0]         r_rem;
  logic [31:0]         r_olen;
  logic [31:0]         r_pend_olen;
  logic [7:0]          r_widx;
  logic [RATE_MAX-1:0] r_asm;
  logic                r_push_pend;
  logic                r_push_last;
  logic                r_live;

  logic                w_acc;
  logic                w_dacc;
  logic                w_last_word;
  logic                w_blk_end;
  logic                w_final_inside;
  logic                w_push_req;
  logic                w_push;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [7:0]          w_nb;
  logic [7:0]          w_pos;
  logic [7:0]          w_rb;
  logic [7:0]          w_rw;
  logic [7:0]          w_dom;
  logic [W-1:0]        w_word;
  logic [RATE_MAX-1:0] w_asm_nxt;
  logic [RATE_MAX-1:0] w_pad_blk;
  logic [FW-1:0]       w_fifo_wdat;
  logic [FW-1:0]       w_fifo_head;

  assign w_rb  = rate_bytes(r_mode);
  assign w_rw  = rate_words(r_mode, W);
  assign w_dom = domain_byte(r_mode);

  assign w_acc          = in_valid && in_ready;
  assign w_dacc         = w_acc && (r_state == DATA);
  assign w_last_word    = (r_rem <= 32'(BPW));
  assign w_nb           = w_last_word ? r_rem[7:0] : 8'(BPW);
  assign w_pos          = r_widx * 8'(BPW) + w_nb;
  assign w_blk_end      = w_dacc && (w_last_word || (r_widx == w_rw - 8'd1));
  assign w_final_inside = w_last_word && (w_pos < w_rb);

  always_comb begin
    w_word = '0;
    for (int b = 0; b < BPW; b++) begin
      if (8'(b) < w_nb) w_word[b*8 +: 8] = in_data[b*8 +: 8];
    end
  end

  // When the message ends inside this block, padding lands in the same write.
  always_comb begin
    w_asm_nxt = r_asm;
    w_asm_nxt[int'(r_widx)*W +: W] = w_word;
    if (w_final_inside) begin
      w_asm_nxt[int'(w_pos)*8 +: 8] = w_asm_nxt[int'(w_pos)*8 +: 8] | w_dom;
      w_asm_nxt[(int'(w_rb)-1)*8 +: 8] = w_asm_nxt[(int'(w_rb)-1)*8 +: 8] | PAD_FINAL;
    end
  end

  always_comb begin
    w_pad_blk = '0;
    w_pad_blk[7:0] = w_dom;
    w_pad_blk[(int'(w_rb)-1)*8 +: 8] = w_pad_blk[(int'(w_rb)-1)*8 +: 8] | PAD_FINAL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= HDR_MODE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HDR_MODE: if (w_acc) w_state_nxt = HDR_LEN;
      HDR_LEN:  if (w_acc) w_state_nxt = HDR_OLEN;
      HDR_OLEN: if (w_acc) w_state_nxt = (r_rem == 32'd0) ? PAD : DATA;
      DATA:     if (w_dacc && w_last_word) w_state_nxt = w_final_inside ? HDR_MODE : PAD;
      PAD:      if (w_push && !r_push_pend) w_state_nxt = HDR_MODE;
      default:  w_state_nxt = HDR_MODE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    w_push_req = r_push_pend;
    case (r_state)
      HDR_MODE, HDR_LEN, HDR_OLEN: in_ready = r_live;
      DATA:    in_ready = r_live && !r_push_pend;
      PAD:     w_push_req = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_push = w_push_req && (!w_fifo_full || (blk_ready && !w_fifo_empty));

  // Pending block snapshots its mode/out_len so the next header can load freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live      <= 1'b0;
      r_mode      <= MODE_SHAKE128;
      r_pend_mode <= MODE_SHAKE128;
      r_rem       <= '0;
      r_olen      <= '0;
      r_pend_olen <= '0;
      r_widx      <= '0;
      r_asm       <= '0;
      r_push_pend <= 1'b0;
      r_push_last <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_acc) begin
        case (r_state)
          HDR_MODE: r_mode <= keccak_mode_t'(in_data[1:0]);
          HDR_LEN:  r_rem  <= in_data[31:0];
          HDR_OLEN: begin
            r_olen <= in_data[31:0];
            r_widx <= '0;
          end
          default: ;
        endcase
      end
      if (w_dacc) begin
        r_asm  <= w_asm_nxt;
        r_rem  <= w_last_word ? 32'd0 : r_rem - 32'(BPW);
        r_widx <= w_blk_end ? 8'd0 : r_widx + 8'd1;
        if (w_blk_end) begin
          r_push_pend <= 1'b1;
          r_push_last <= w_final_inside;
          r_pend_mode <= r_mode;
          r_pend_olen <= r_olen;
        end
      end
      if (w_push && r_push_pend) begin
        r_push_pend <= 1'b0;
        r_asm       <= '0;
      end
    end
  end

  assign w_fifo_wdat = r_push_pend ? {r_asm, r_push_last, r_pend_mode, r_pend_olen}
                                   : {w_pad_blk, 1'b1, r_mode, r_olen};

  keccak_block_fifo #(
    .DW    (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_dat   (w_fifo_wdat),
    .i_pop   (blk_ready),
    .o_dat   (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign blk_valid   = !w_fifo_empty;
  assign blk_data    = w_fifo_head[FW-1 -: RATE_MAX];
  assign blk_last    = w_fifo_head[34];
  assign blk_mode    = w_fifo_head[33:32];
  assign blk_out_len = w_fifo_head[31:0];

`ifdef KECCAK_FRONTEND_STATS_EN
  logic [31:0] r_blk_count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        r_blk_count <= '0;
    else if (blk_valid && blk_ready) r_blk_count <= r_blk_count + 32'd1;
  end
  assign blk_count = r_blk_count;
`else
  assign blk_count = '0;
`endif

endmodule

// File: tb/tb_keccak_absorb_frontend.sv
// Directed bench for keccak_absorb_frontend: W=64 main instance plus a W=32 instance.
module tb_keccak_absorb_frontend;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          blk_valid;
  logic          blk_ready;
  logic [1343:0] blk_data;
  logic          blk_last;
  logic [1:0]    blk_mode;
  logic [31:0]   blk_out_len;
  logic [31:0]   blk_count;

  logic          n_in_valid;
  logic          n_in_ready;
  logic [31:0]   n_in_data;
  logic          n_blk_valid;
  logic          n_blk_ready;
  logic [1343:0] n_blk_data;
  logic          n_blk_last;
  logic [1:0]    n_blk_mode;
  logic [31:0]   n_blk_out_len;
  logic [31:0]   n_blk_count;

  keccak_absorb_frontend #(.W(64), .DEPTH(2), .RATE_MAX(1344)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .blk_mode(blk_mode), .blk_out_len(blk_out_len), .blk_count(blk_count)
  );

  keccak_absorb_frontend #(.W(32), .DEPTH(2), .RATE_MAX(1344)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .blk_valid(n_blk_valid), .blk_ready(n_blk_ready), .blk_data(n_blk_data), .blk_last(n_blk_last),
    .blk_mode(n_blk_mode), .blk_out_len(n_blk_out_len), .blk_count(n_blk_count)
  );

  int checks = 0;
  int failures = 0;
  int exp_pops = 0;

  logic [1343:0] g_data;
  logic          g_last;
  logic [1:0]    g_mode;
  logic [31:0]   g_olen;

  function automatic int first_diff(input logic [1343:0] a, input logic [1343:0] b);
    for (int i = 0; i < 168; i++) if (a[i*8 +: 8] !== b[i*8 +: 8]) return i;
    return 0;
  endfunction

  function automatic logic [63:0] wval(input int j);
    return {32'hC0DE0000 | 32'(j), 32'(j * 7 + 3)};
  endfunction

  function automatic logic [1343:0] make_blk(input int first, input int n);
    logic [1343:0] v = '0;
    for (int i = 0; i < n; i++) v[i*64 +: 64] = wval(first + i);
    return v;
  endfunction

  function automatic logic [31:0] exp_count();
`ifdef KECCAK_FRONTEND_STATS_EN
    return 32'(exp_pops);
`else
    return 32'd0;
`endif
  endfunction

  task automatic send(input logic [63:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready=%b word=%h", in_ready, d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d);
    int n = 0;
    n_in_data  = d;
    n_in_valid = 1'b1;
    while (n_in_ready !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL send32_timeout in_ready=%b word=%h", n_in_ready, d);
    end
    @(posedge clk); #1;
    n_in_valid = 1'b0;
  endtask

  task automatic get_block();
    int n = 0;
    while (blk_valid !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
    if (blk_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL get_block_timeout blk_valid=%b", blk_valid);
    end else begin
      exp_pops++;
    end
    g_data = blk_data; g_last = blk_last; g_mode = blk_mode; g_olen = blk_out_len;
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (blk_valid !== 1'b0) begin failures++; $display("FAIL rst_blk_valid got %b want 0", blk_valid); end
    checks++; if (blk_data !== '0) begin failures++; $display("FAIL rst_blk_data nonzero byte %0d", first_diff(blk_data, '0)); end
    checks++; if (blk_last !== 1'b0) begin failures++; $display("FAIL rst_blk_last got %b want 0", blk_last); end
    checks++; if (blk_mode !== 2'd0) begin failures++; $display("FAIL rst_blk_mode got %0d want 0", blk_mode); end
    checks++; if (blk_out_len !== 32'd0) begin failures++; $display("FAIL rst_out_len got %0d want 0", blk_out_len); end
    checks++; if (blk_count !== 32'd0) begin failures++; $display("FAIL rst_blk_count got %0d want 0", blk_count); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_shake128_empty();
    logic [1343:0] exp = '0;
    exp[7:0] = 8'h1F;
    exp[167*8 +: 8] = 8'h80;
    send(64'd0); send(64'd0); send(64'd256);
    get_block();
    checks++; if (g_data !== exp) begin failures++; $display("FAIL empty_data byte %0d got %h want %h", first_diff(g_data, exp), g_data[first_diff(g_data, exp)*8 +: 8], exp[first_diff(g_data, exp)*8 +: 8]); end
    checks++; if (g_last !== 1'b1) begin failures++; $display("FAIL empty_last got %b want 1", g_last); end
    checks++; if (g_mode !== 2'd0) begin failures++; $display("FAIL empty_mode got %0d want 0", g_mode); end
    checks++; if (g_olen !== 32'd256) begin failures++; $display("FAIL empty_out_len got %0d want 256", g_olen); end
    checks++; if (blk_count !== exp_count()) begin failures++; $display("FAIL empty_blk_count got %0d want %0d", blk_count, exp_count()); end
  endtask

  task automatic test_sha3_256_partial();
    logic [1343:0] exp = '0;
    logic [63:0] w;
    for (int i = 0; i < 135; i++) exp[i*8 +: 8] = 8'(i);
    exp[135*8 +: 8] = 8'h86;
    send(64'd2); send(64'd135); send(64'd256);
    for (int k = 0; k < 17; k++) begin
      for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'(8 * k + b);
      send(w);
    end
    checks++; if (blk_valid !== 1'b0) begin failures++; $display("FAIL lat_early blk_valid got %b want 0", blk_valid); end
    @(posedge clk); #1;
    checks++; if (blk_valid !== 1'b1) begin failures++; $display("FAIL lat_t1 blk_valid got %b want 1", blk_valid); end
    get_block();
    checks++; if (g_data !== exp) begin failures++; $display("FAIL l135_data byte %0d got %h want %h", first_diff(g_data, exp), g_data[first_diff(g_data, exp)*8 +: 8], exp[first_diff(g_data, exp)*8 +: 8]); end
    checks++; if (g_data[1343:1088] !== '0) begin failures++; $display("FAIL l135_above_rate nonzero byte %0d", first_diff(g_data, exp)); end
    checks++; if (g_last !== 1'b1) begin failures++; $display("FAIL l135_last got %b want 1", g_last); end
    checks++; if (g_mode !== 2'd2) begin failures++; $display("FAIL l135_mode got %0d want 2", g_mode); end
  endtask

  task automatic test_sha3_256_exact();
    logic [1343:0] exp1 = '0;
    logic [1343:0] exp2 = '0;
    logic [63:0] w;
    for (int i = 0; i < 136; i++) exp1[i*8 +: 8] = 8'(i) ^ 8'h5A;
    exp2[7:0] = 8'h06;
    exp2[135*8 +: 8] = 8'h80;
    send(64'd2); send(64'd136); send(64'd512);
    for (int k = 0; k < 17; k++) begin
      for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'(8 * k + b) ^ 8'h5A;
      send(w);
    end
    get_block();
    checks++; if (g_data !== exp1) begin failures++; $display("FAIL l136_b1_data byte %0d got %h want %h", first_diff(g_data, exp1), g_data[first_diff(g_data, exp1)*8 +: 8], exp1[first_diff(g_data, exp1)*8 +: 8]); end
    checks++; if (g_last !== 1'b0) begin failures++; $display("FAIL l136_b1_last got %b want 0", g_last); end
    checks++; if (g_olen !== 32'd512) begin failures++; $display("FAIL l136_b1_out_len got %0d want 512", g_olen); end
    get_block();
    checks++; if (g_data !== exp2) begin failures++; $display("FAIL l136_b2_data byte %0d got %h want %h", first_diff(g_data, exp2), g_data[first_diff(g_data, exp2)*8 +: 8], exp2[first_diff(g_data, exp2)*8 +: 8]); end
    checks++; if (g_last !== 1'b1) begin failures++; $display("FAIL l136_b2_last got %b want 1", g_last); end
    checks++; if (g_mode !== 2'd2) begin failures++; $display("FAIL l136_b2_mode got %0d want 2", g_mode); end
  endtask

  task automatic test_w32_mask();
    logic [1343:0] exp = '0;
    int n = 0;
    exp[31:0] = 32'h03020100;
    exp[39:32] = 8'hFF;
    exp[47:40] = 8'h1F;
    exp[135*8 +: 8] = 8'h80;
    send32(32'd1); send32(32'd5); send32(32'd512);
    send32(32'h03020100); send32(32'hFFFFFFFF);
    while (n_blk_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (n_blk_valid !== 1'b1) begin failures++; $display("FAIL w32_valid got %b want 1", n_blk_valid); end
    checks++; if (n_blk_data[63:40] !== 24'h00001F) begin failures++; $display("FAIL w32_bytes5to7 got %h want 00001f", n_blk_data[63:40]); end
    checks++; if (n_blk_data !== exp) begin failures++; $display("FAIL w32_data byte %0d got %h want %h", first_diff(n_blk_data, exp), n_blk_data[first_diff(n_blk_data, exp)*8 +: 8], exp[first_diff(n_blk_data, exp)*8 +: 8]); end
    checks++; if (n_blk_last !== 1'b1 || n_blk_mode !== 2'd1) begin failures++; $display("FAIL w32_last_mode got %b/%0d want 1/1", n_blk_last, n_blk_mode); end
    n_blk_ready = 1'b1;
    @(posedge clk); #1;
    n_blk_ready = 1'b0;
    checks++; if (n_blk_valid !== 1'b0) begin failures++; $display("FAIL w32_drained blk_valid got %b want 0", n_blk_valid); end
  endtask

  task automatic test_backpressure();
    logic [1343:0] exp;
    send(64'd3); send(64'd224); send(64'd1000);
    for (int j = 0; j < 27; j++) send(wval(j));
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall in_ready got %b want 0", in_ready); end
    exp = make_blk(0, 9);
    checks++; if (blk_data !== exp || blk_valid !== 1'b1) begin failures++; $display("FAIL bp_head0 valid=%b byte %0d got %h want %h", blk_valid, first_diff(blk_data, exp), blk_data[first_diff(blk_data, exp)*8 +: 8], exp[first_diff(blk_data, exp)*8 +: 8]); end
    blk_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_pulse in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    blk_ready = 1'b0;
    exp_pops++;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_restore in_ready got %b want 1", in_ready); end
    send(wval(27));
    for (int b = 1; b <= 2; b++) begin
      exp = make_blk(9 * b, 9);
      get_block();
      checks++; if (g_data !== exp) begin failures++; $display("FAIL bp_blk%0d_data byte %0d got %h want %h", b, first_diff(g_data, exp), g_data[first_diff(g_data, exp)*8 +: 8], exp[first_diff(g_data, exp)*8 +: 8]); end
      checks++; if (g_last !== 1'b0 || g_mode !== 2'd3) begin failures++; $display("FAIL bp_blk%0d_last_mode got %b/%0d want 0/3", b, g_last, g_mode); end
    end
    exp = make_blk(27, 1);
    exp[8*8 +: 8] = 8'h06;
    exp[71*8 +: 8] = 8'h80;
    get_block();
    checks++; if (g_data !== exp) begin failures++; $display("FAIL bp_blk3_data byte %0d got %h want %h", first_diff(g_data, exp), g_data[first_diff(g_data, exp)*8 +: 8], exp[first_diff(g_data, exp)*8 +: 8]); end
    checks++; if (g_last !== 1'b1 || g_olen !== 32'd1000) begin failures++; $display("FAIL bp_blk3_last_olen got %b/%0d want 1/1000", g_last, g_olen); end
    checks++; if (blk_count !== exp_count()) begin failures++; $display("FAIL bp_blk_count got %0d want %0d", blk_count, exp_count()); end
  endtask

  task automatic test_reset_mid();
    logic [1343:0] exp = '0;
    for (int i = 0; i < 8; i++) exp[i*8 +: 8] = 8'(i + 1);
    exp[8*8 +: 8] = 8'h06;
    exp[71*8 +: 8] = 8'h80;
    send(64'd0); send(64'd0); send(64'd64);
    @(posedge clk); #1;
    checks++; if (blk_valid !== 1'b1) begin failures++; $display("FAIL rm_preload blk_valid got %b want 1", blk_valid); end
    send(64'd1); send(64'd100); send(64'd128);
    send(wval(0)); send(wval(1));
    #2; rst = 1'b0; #1;
    exp_pops = 0;
    checks++; if (blk_valid !== 1'b0) begin failures++; $display("FAIL rm_blk_valid got %b want 0", blk_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rm_in_ready got %b want 0", in_ready); end
    checks++; if (blk_count !== 32'd0) begin failures++; $display("FAIL rm_blk_count got %0d want 0", blk_count); end
    @(posedge clk); #1; rst = 1'b1;
    send(64'd3); send(64'd8); send(64'd256); send(64'h0807060504030201);
    get_block();
    checks++; if (g_data !== exp) begin failures++; $display("FAIL rm_data byte %0d got %h want %h", first_diff(g_data, exp), g_data[first_diff(g_data, exp)*8 +: 8], exp[first_diff(g_data, exp)*8 +: 8]); end
    checks++; if (g_last !== 1'b1 || g_mode !== 2'd3) begin failures++; $display("FAIL rm_last_mode got %b/%0d want 1/3", g_last, g_mode); end
    checks++; if (blk_count !== exp_count()) begin failures++; $display("FAIL rm_blk_count_after got %0d want %0d", blk_count, exp_count()); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (blk_valid !== 1'b0) begin failures++; $display("FAIL rm_no_stale blk_valid got %b want 0", blk_valid); end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; blk_ready = 1'b0;
    n_in_valid = 1'b0; n_in_data = '0; n_blk_ready = 1'b0;
    test_reset();
    test_shake128_empty();
    test_sha3_256_partial();
    test_sha3_256_exact();
    test_w32_mask();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
